// File: rtl/cnn_pkg.sv
// Shared CNN-pipeline types: default sample width, pooling FSM states and a signed max helper.
package cnn_pkg;

    localparam int T = 12;

    typedef logic signed [T-1:0] sample_t;

    typedef enum logic {
        ACCUM,
        OUTPUT
    } pool_state_t;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_1d.sv
// Streaming 1-D max-pool (window/stride P) over frames of L signed samples.
// Optional macro POOL_PARTIAL_EN: emit the short trailing window of L mod P samples.
module max_pool_1d #(
    parameter int L = 13,
    parameter int P = 2,
    parameter int T = cnn_pkg::T
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] x_data,
    input  logic         x_valid,
    output logic         x_ready,
    output logic [T-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         y_last
);
    import cnn_pkg::*;

    localparam int WW        = $clog2(P);
    localparam int FW        = $clog2(L);
    localparam int LAST_FULL = (L / P) * P - 1;

    pool_state_t            state;
    pool_state_t            state_next;
    logic [WW-1:0]          win_cnt;
    logic [FW-1:0]          frame_cnt;
    logic signed [T-1:0]    max_reg;
    logic signed [T-1:0]    x_s;
    logic                   last_reg;
    logic                   accept;
    logic                   win_full;
    logic                   frame_end;
    logic                   close;
    logic                   close_last;

    assign x_s       = x_data;
    assign accept    = x_valid && x_ready;
    assign win_full  = (win_cnt == WW'(P - 1));
    assign frame_end = (frame_cnt == FW'(L - 1));

    // Without the partial feature the remainder samples are swallowed and the
    // last full window carries the frame marker instead.
`ifdef POOL_PARTIAL_EN
    assign close      = accept && (win_full || frame_end);
    assign close_last = frame_end;
`else
    assign close      = accept && win_full;
    assign close_last = (frame_cnt == FW'(LAST_FULL));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            win_cnt   <= '0;
            frame_cnt <= '0;
            max_reg   <= '0;
            last_reg  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                max_reg   <= (win_cnt == '0) ? x_s : ((x_s > max_reg) ? x_s : max_reg);
                frame_cnt <= frame_end ? '0 : frame_cnt + FW'(1);
                win_cnt   <= (win_full || frame_end) ? '0 : win_cnt + WW'(1);
                if (close) begin
                    last_reg <= close_last;
                end
            end
            if (y_valid && y_ready) begin
                win_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (close)   state_next = OUTPUT;
            OUTPUT:  if (y_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Handshake outputs are masked during reset so nothing transfers while it is held.
    always_comb begin
        x_ready = 1'b0;
        y_valid = 1'b0;
        if (!reset) begin
            x_ready = (state == ACCUM);
            y_valid = (state == OUTPUT);
        end
        y_data = max_reg;
        y_last = y_valid && last_reg;
    end

endmodule

// File: tb/tb_max_pool_1d.sv
// Self-checking bench for max_pool_1d: two instances (L=13,P=2 and L=12,P=3) against a
// frame-buffer reference model; honours POOL_PARTIAL_EN when defined for the build.
module tb_max_pool_1d;

    localparam int T  = 12;
    localparam int LA = 13;
    localparam int PA = 2;
    localparam int LB = 12;
    localparam int PB = 3;
`ifdef POOL_PARTIAL_EN
    localparam bit PARTIAL = 1'b1;
`else
    localparam bit PARTIAL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [T-1:0] x_data  [2];
    logic         x_valid [2];
    logic         x_ready [2];
    logic [T-1:0] y_data  [2];
    logic         y_valid [2];
    logic         y_ready [2];
    logic         y_last  [2];

    int total = 0;
    int bad   = 0;

    // Reference model state: samples of the current frame, expected and observed outputs.
    int frm  [2][$];
    int expD [2][$];
    bit expL [2][$];
    int obsD [2][$];
    bit obsL [2][$];
    bit rndReady [2];
    bit holdPrev [2];
    int prevData [2];
    bit prevLast [2];

    always #5 clk = ~clk;

    max_pool_1d #(.L(LA), .P(PA), .T(T)) dut_a (
        .clk(clk), .reset(reset),
        .x_data(x_data[0]), .x_valid(x_valid[0]), .x_ready(x_ready[0]),
        .y_data(y_data[0]), .y_valid(y_valid[0]), .y_ready(y_ready[0]), .y_last(y_last[0])
    );

    max_pool_1d #(.L(LB), .P(PB), .T(T)) dut_b (
        .clk(clk), .reset(reset),
        .x_data(x_data[1]), .x_valid(x_valid[1]), .x_ready(x_ready[1]),
        .y_data(y_data[1]), .y_valid(y_valid[1]), .y_ready(y_ready[1]), .y_last(y_last[1])
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int qmax(input int q[$], input int lo, input int hi);
        int m;
        m = q[lo];
        for (int i = lo + 1; i <= hi; i++) if (q[i] > m) m = q[i];
        return m;
    endfunction

    // Per-cycle checker and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int lv;
            int pv;
            int n;
            int lo;
            lv = (d == 0) ? LA : LB;
            pv = (d == 0) ? PA : PB;
            if (reset) begin
                checkOutput($sformatf("d%0d reset x_ready", d), int'(x_ready[d]), 0);
                checkOutput($sformatf("d%0d reset y_valid", d), int'(y_valid[d]), 0);
                frm[d].delete();
                expD[d].delete();
                expL[d].delete();
                holdPrev[d] = 1'b0;
            end else begin
                checkOutput($sformatf("d%0d x_ready", d), int'(x_ready[d]), int'(!y_valid[d]));
                if (holdPrev[d]) begin
                    checkOutput($sformatf("d%0d hold valid", d), int'(y_valid[d]), 1);
                    checkOutput($sformatf("d%0d hold data", d), int'($signed(y_data[d])), prevData[d]);
                    checkOutput($sformatf("d%0d hold last", d), int'(y_last[d]), int'(prevLast[d]));
                end
                holdPrev[d] = y_valid[d] && !y_ready[d];
                prevData[d] = int'($signed(y_data[d]));
                prevLast[d] = y_last[d];
                if (y_valid[d] && y_ready[d]) begin
                    if (expD[d].size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL d%0d unexpected output: got %0d, expected none", d,
                                 int'($signed(y_data[d])));
                    end else begin
                        checkOutput($sformatf("d%0d y_data", d), int'($signed(y_data[d])), expD[d].pop_front());
                        checkOutput($sformatf("d%0d y_last", d), int'(y_last[d]), int'(expL[d].pop_front()));
                    end
                    obsD[d].push_back(int'($signed(y_data[d])));
                    obsL[d].push_back(y_last[d]);
                end
                if (x_valid[d] && x_ready[d]) begin
                    frm[d].push_back(int'($signed(x_data[d])));
                    n = frm[d].size();
                    if (n % pv == 0) begin
                        lo = n - pv;
                        expD[d].push_back(qmax(frm[d], lo, n - 1));
                        expL[d].push_back(n == (lv / pv) * pv);
                    end else if (PARTIAL && n == lv) begin
                        lo = n - (lv % pv);
                        expD[d].push_back(qmax(frm[d], lo, n - 1));
                        expL[d].push_back(1'b1);
                    end
                    if (n == lv) frm[d].delete();
                end
            end
        end
    end

    // Random backpressure when enabled for an instance.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) if (rndReady[d]) y_ready[d] = 1'($urandom_range(0, 1));
    end

    task automatic applyStimulus(input int d, input int vals[$], input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < vals.size() && guard < 5000) begin
            x_data[d]  = T'(vals[i]);
            x_valid[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (x_valid[d] && x_ready[d] && !reset) i++;
            @(posedge clk);
            #1;
            guard++;
        end
        x_valid[d] = 1'b0;
        if (i < vals.size()) begin
            total++;
            bad++;
            $display("[TB] FAIL d%0d input timeout: got %0d accepted, expected %0d", d, i, vals.size());
        end
    endtask

    task automatic waitIdle(input int d);
        int guard = 0;
        while ((expD[d].size() != 0 || y_valid[d]) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 300) begin
            total++;
            bad++;
            $display("[TB] FAIL d%0d drain timeout: got %0d pending, expected 0", d, expD[d].size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic checkSeq(input int d, input string name, input int exp[$]);
        checkOutput({name, " count"}, obsD[d].size(), exp.size());
        for (int i = 0; i < exp.size() && i < obsD[d].size(); i++) begin
            checkOutput($sformatf("%s data[%0d]", name, i), obsD[d][i], exp[i]);
            checkOutput($sformatf("%s last[%0d]", name, i), int'(obsL[d][i]), int'(i == exp.size() - 1));
        end
    endtask

    task automatic clearObs(input int d);
        obsD[d].delete();
        obsL[d].delete();
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        int v[$];
        int e[$];
        int nout;
        int lastCount;
        reset    = 1'b1;
        x_valid  = '{1'b0, 1'b0};
        x_data   = '{'0, '0};
        y_ready  = '{1'b1, 1'b1};
        rndReady = '{1'b0, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // State in the first cycle after reset.
        @(negedge clk);
        checkOutput("post-reset x_ready", int'(x_ready[0]), 1);
        checkOutput("post-reset y_valid", int'(y_valid[0]), 0);
        checkOutput("post-reset y_last", int'(y_last[0]), 0);
        checkOutput("post-reset y_data", int'(y_data[0]), 0);
        @(posedge clk);
        #1;

        // Ramp 1..13 at full rate.
        v = {};
        for (int i = 1; i <= 13; i++) v.push_back(i);
        e = {2, 4, 6, 8, 10, 12};
        if (PARTIAL) e.push_back(13);
        clearObs(0);
        applyStimulus(0, v, 1'b0);
        waitIdle(0);
        checkSeq(0, "ramp", e);

        // Signed comparison on negative samples.
        clearObs(0);
        applyStimulus(0, '{-5, -3, 7, 0}, 1'b0);
        waitIdle(0);
        checkOutput("signed count", obsD[0].size(), 2);
        if (obsD[0].size() == 2) begin
            checkOutput("signed first", obsD[0][0], -3);
            checkOutput("signed second", obsD[0][1], 7);
        end
        pulseReset();

        // Backpressure held for five cycles after the first window.
        clearObs(0);
        y_ready[0] = 1'b0;
        fork
            applyStimulus(0, v, 1'b0);
            begin
                int g = 0;
                while (!y_valid[0] && g < 100) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checkOutput("stall y_valid", int'(y_valid[0]), 1);
                    checkOutput("stall y_data", int'($signed(y_data[0])), 2);
                    checkOutput("stall x_ready", int'(x_ready[0]), 0);
                    @(posedge clk);
                    #1;
                end
                y_ready[0] = 1'b1;
            end
        join
        waitIdle(0);
        checkSeq(0, "stall", e);

        // Reset part-way through a frame, then a fresh frame with no stale max.
        applyStimulus(0, '{100, 90, 80}, 1'b0);
        x_valid[0] = 1'b1;
        x_data[0]  = T'(55);
        reset      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("mid reset x_ready", int'(x_ready[0]), 0);
            checkOutput("mid reset y_valid", int'(y_valid[0]), 0);
            @(posedge clk);
            #1;
        end
        reset      = 1'b0;
        x_valid[0] = 1'b0;
        clearObs(0);
        v = {};
        for (int i = 20; i <= 32; i++) v.push_back(i);
        e = {21, 23, 25, 27, 29, 31};
        if (PARTIAL) e.push_back(32);
        applyStimulus(0, v, 1'b0);
        waitIdle(0);
        checkSeq(0, "after reset", e);

        // Two random frames with random valid and ready.
        pulseReset();
        clearObs(0);
        v = {};
        for (int i = 0; i < 2 * LA; i++) v.push_back(int'($urandom_range(0, 4095)) - 2048);
        rndReady[0] = 1'b1;
        applyStimulus(0, v, 1'b1);
        rndReady[0] = 1'b0;
        y_ready[0]  = 1'b1;
        waitIdle(0);
        nout = PARTIAL ? (LA + PA - 1) / PA : LA / PA;
        checkOutput("random count", obsD[0].size(), 2 * nout);
        lastCount = 0;
        foreach (obsL[0][i]) if (obsL[0][i]) lastCount++;
        checkOutput("random last count", lastCount, 2);
        if (obsD[0].size() == 2 * nout) begin
            checkOutput("random last frame0", int'(obsL[0][nout - 1]), 1);
            checkOutput("random last frame1", int'(obsL[0][2 * nout - 1]), 1);
        end

        // L=12, P=3 descending ramp: no remainder, so both builds agree.
        clearObs(1);
        v = {};
        for (int i = 12; i >= 1; i--) v.push_back(i);
        applyStimulus(1, v, 1'b0);
        waitIdle(1);
        checkSeq(1, "p3 ramp", '{12, 9, 6, 3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/max_pool_1d.md
Name: max_pool_1d

Overview:
- Streaming 1-D max-pool stage directly downstream of the convolution/ReLU engine.
- Consumes one y frame of L signed T-bit samples over a valid/ready handshake.
- Emits the maximum of each non-overlapping window of P samples (stride P) over a second valid/ready handshake toward the next layer.
- Frames are processed back to back with no reconfiguration.

Parameters:
- L, 13, samples per input frame (conv output length N-M+1).
- P, 2, pool window size and stride; 2 <= P <= L.
- T, 12, signed sample width; matches the conv stage T.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- x_data  input  T  signed input sample from the conv stage.
- x_valid  input  1  x_data valid.
- x_ready  output  1  block accepts x_data this cycle.
- y_data  output  T  signed pooled maximum.
- y_valid  output  1  y_data valid.
- y_ready  input  1  downstream accepts y_data.
- y_last  output  1  qualifies y_data as the last pooled value of the frame; meaningful only while y_valid=1.

Behaviour:
- Reset (synchronous, active-high):
  - state=ACCUM; win_cnt=0; frame_cnt=0; max_reg=0.
  - y_valid=0, y_last=0, y_data=0.
  - x_ready is forced to 0 while reset=1 and is 1 in the first cycle after reset deasserts.
  - Reset mid-frame discards the partial window and partial frame. No output is produced for it.
- Handshakes:
  - An input transfer happens when x_valid&&x_ready.
  - An output transfer happens when y_valid&&y_ready.
  - y_data and y_last hold stable while y_valid=1 and y_ready=0.
- States:
  - ACCUM: x_ready=1, y_valid=0.
  - OUTPUT: x_ready=0, y_valid=1.
- On each accepted input in ACCUM:
  - If win_cnt==0, max_reg<=x_data; otherwise max_reg<=(x_data>max_reg)?x_data:max_reg, using a signed compare.
  - frame_cnt increments and wraps to 0 after L-1.
  - win_cnt increments and resets to 0 when the window closes.
- Window close:
  - A window closes on acceptance of the sample with win_cnt==P-1.
  - It also closes on the frame's final sample; see the optional feature.
  - On close, the next state is OUTPUT. y_valid asserts in the cycle after the closing accept (latency 1).
- OUTPUT:
  - y_data=max_reg.
  - y_last=1 iff this window contains the frame's final sample.
  - On output transfer: state=ACCUM and win_cnt=0 (next sample starts a new window).
- Frame boundary:
  - A window never spans two frames.
  - win_cnt is forced to 0 when frame_cnt wraps.
- Remainder samples:
  - L mod P trailing samples are always consumed (x_ready=1), so upstream never stalls.
  - Whether they produce an output is set by the optional feature.
- Throughput: minimum P+1 cycles per pooled output. Input is stalled only in OUTPUT.
- Arithmetic: pure selection; no widening and no saturation.
- Negative inputs are compared correctly, even though ReLU upstream normally delivers values >= 0.
- Outputs per frame: floor(L/P), or ceil(L/P) with POOL_PARTIAL_EN.

Optional Feature:
- Macro POOL_PARTIAL_EN.
- Defined:
  - The frame's final sample closes a short window of L mod P samples, which is emitted with y_last=1.
  - Outputs per frame = ceil(L/P).
- Undefined:
  - Remainder samples are accepted and dropped; no output is produced for them.
  - y_last=1 on the last full window.
  - Outputs per frame = floor(L/P).
- When L mod P==0, both builds behave identically.

Decomposition:
- Shared package cnn_pkg:
  - default T;
  - typedef logic signed [T-1:0] sample_t;
  - enum pool_state_t {ACCUM, OUTPUT};
  - function smax(a,b) for the signed maximum.
- The datapath is small, so no sub-module is needed.
- FSM and counters are kept in one always_ff/always_comb pair within max_pool_1d.

Test Plan (L=13, P=2, T=12 unless noted):
- Continuous stream 1..13 with y_ready=1:
  - without the macro, outputs 2,4,6,8,10,12, y_last on 12, sample 13 consumed silently;
  - with POOL_PARTIAL_EN, a seventh output 13 with y_last=1.
- Window {-5,-3}, then {7,0}: outputs -3 then 7, checking the signed compare.
- Hold y_ready=0 for 5 cycles after the first window closes: y_valid stays 1 with y_data stable, x_ready=0, and no input is lost when y_ready returns.
- Assert reset after 3 samples of a frame: y_valid=0 and x_ready=0 during reset, then a new frame 20..32 gives first output 21, with no stale max.
- Two frames back to back, with x_valid toggling randomly: windows never span the frame boundary, and y_last appears once per frame.
- L=12, P=3, samples 12 down to 1: outputs 12,9,6,3 with y_last on 3, identical with and without POOL_PARTIAL_EN.
